// File: rtl/vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : vga_mode_ctrl
// Purpose  : Sequences run-time timing-mode changes for vga_sync. A mode
//            request arrives over a four-phase req/ack handshake. The new mode
//            is applied only at a frame boundary, or when the watchdog expires.
//            A one-cycle sync reset is then pulsed, and video is blanked for a
//            programmable number of settle frames.
// Revision : 1.0 - initial release
// ============================================================================
module vga_mode_ctrl #(
    parameter bit          RESET_MODE     = 1'b0,
    parameter int unsigned SETTLE_FRAMES  = 2,
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_req,
    input  logic       i_req_mode,
    input  logic       i_hmax,
    input  logic       i_vmax,
    output logic       o_mode,
    output logic       o_sync_reset,
    output logic       o_blank_force,
    output logic       o_busy,
    output logic       o_ack,
    output logic       o_timeout,
    output logic [7:0] o_frame_count
);

    localparam logic [1:0]  c_ST_IDLE     = 2'd0;
    localparam logic [1:0]  c_ST_WAIT_EOF = 2'd1;
    localparam logic [1:0]  c_ST_SETTLE   = 2'd2;
    localparam logic [1:0]  c_ST_ACK      = 2'd3;

    localparam logic [3:0]  c_SETTLE_INIT = 4'(SETTLE_FRAMES);
    localparam logic [19:0] c_WD_LAST     = 20'(TIMEOUT_CYCLES - 1);
    localparam bit          c_NO_SETTLE   = (SETTLE_FRAMES == 0);

    logic [1:0]  r_state;
    logic        r_pending;
    logic [19:0] r_wd;
    logic [3:0]  r_settle;
    logic        r_mode;
    logic        r_sync_reset;
    logic        r_blank_force;
    logic        r_busy;
    logic        r_ack;
    logic        r_timeout;
    logic [7:0]  r_frame_count;

    logic        w_eof;
    logic        w_wd_hit;
    logic        w_apply;

    assign w_eof    = i_hmax & i_vmax;
    assign w_wd_hit = (r_wd == c_WD_LAST);
    // An apply fires on the frame boundary. The watchdog only forces it when the boundary never shows up.
    assign w_apply  = (r_state == c_ST_WAIT_EOF) & (w_eof | w_wd_hit);

    // Mode sequencer, frame counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_pending     <= RESET_MODE;
            r_wd          <= '0;
            r_settle      <= '0;
            r_mode        <= RESET_MODE;
            r_sync_reset  <= 1'b1;
            r_blank_force <= 1'b0;
            r_busy        <= 1'b0;
            r_ack         <= 1'b0;
            r_timeout     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            // The sync reset is a single-cycle pulse unless an apply re-arms it below.
            r_sync_reset <= 1'b0;

            // Clearing on apply takes priority over counting the boundary.
            if (w_apply) begin
                r_frame_count <= '0;
            end else if (w_eof) begin
                r_frame_count <= r_frame_count + 8'd1;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (i_req) begin
                        if (i_req_mode == r_mode) begin
                            r_state <= c_ST_ACK;
                        end else begin
                            r_pending <= i_req_mode;
                            r_timeout <= 1'b0;
                            r_wd      <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= c_ST_WAIT_EOF;
                        end
                    end
                end

                c_ST_WAIT_EOF: begin
                    r_wd <= r_wd + 20'd1;
                    if (w_apply) begin
                        r_mode       <= r_pending;
                        r_sync_reset <= 1'b1;
                        r_settle     <= c_SETTLE_INIT;
                        // A boundary arriving on the same cycle as expiry counts as a clean apply.
                        r_timeout    <= ~w_eof;
                        if (c_NO_SETTLE) begin
                            r_busy  <= 1'b0;
                            r_state <= c_ST_ACK;
                        end else begin
                            r_blank_force <= 1'b1;
                            r_state       <= c_ST_SETTLE;
                        end
                    end
                end

                c_ST_SETTLE: begin
                    if (w_eof) begin
                        r_settle <= r_settle - 4'd1;
                        if (r_settle == 4'd1) begin
                            r_blank_force <= 1'b0;
                            r_busy        <= 1'b0;
                            r_state       <= c_ST_ACK;
                        end
                    end
                end

                c_ST_ACK: begin
                    if (!i_req) begin
                        r_ack   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_ack <= 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign o_mode        = r_mode;
    assign o_sync_reset  = r_sync_reset;
    assign o_blank_force = r_blank_force;
    assign o_busy        = r_busy;
    assign o_ack         = r_ack;
    assign o_timeout     = r_timeout;
    assign o_frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_mode_ctrl
// Purpose  : Directed self-checking bench for vga_mode_ctrl. It uses a short
//            synthetic 10x5 frame (50 cycles). Instance dut uses RESET_MODE=0,
//            SETTLE_FRAMES=2 and TIMEOUT_CYCLES=1000. Instance dut0 uses
//            RESET_MODE=1 and SETTLE_FRAMES=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_mode_ctrl;

    localparam int H = 10;
    localparam int V = 5;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       req   = 1'b0;
    logic       rmode = 1'b0;
    logic       req0  = 1'b0;
    logic       rmode0 = 1'b1;
    logic       hen   = 1'b1;
    logic       hmax;
    logic       vmax;

    logic       mode, sr, blank, busy, ack, tmo;
    logic [7:0] fc;
    logic       mode0, sr0, blank0, busy0, ack0, tmo0;
    logic [7:0] fc0;

    int n_checks = 0;
    int n_errors = 0;
    int hc = 0;
    int vc = 0;
    logic blank0_seen = 1'b0;

    vga_mode_ctrl #(.RESET_MODE(1'b0), .SETTLE_FRAMES(2), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .i_req(req), .i_req_mode(rmode),
        .i_hmax(hmax), .i_vmax(vmax), .o_mode(mode), .o_sync_reset(sr),
        .o_blank_force(blank), .o_busy(busy), .o_ack(ack), .o_timeout(tmo),
        .o_frame_count(fc)
    );

    vga_mode_ctrl #(.RESET_MODE(1'b1), .SETTLE_FRAMES(0), .TIMEOUT_CYCLES(1000)) dut0 (
        .clk(clk), .reset(reset), .i_req(req0), .i_req_mode(rmode0),
        .i_hmax(hmax), .i_vmax(vmax), .o_mode(mode0), .o_sync_reset(sr0),
        .o_blank_force(blank0), .o_busy(busy0), .o_ack(ack0), .o_timeout(tmo0),
        .o_frame_count(fc0)
    );

    always #5 clk = ~clk;

    // Synthetic raster: advances on the falling edge so the DUT sees stable inputs.
    always @(negedge clk) begin
        if (hc == H - 1) begin
            hc = 0;
            vc = (vc == V - 1) ? 0 : vc + 1;
        end else begin
            hc = hc + 1;
        end
    end

    assign hmax = hen && (hc == H - 1);
    assign vmax = (vc == V - 1);

    // The zero-settle instance must never raise its blanking output.
    always @(negedge clk) begin
        if (blank0) blank0_seen = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to the edge that samples a frame boundary.
    task automatic wait_eof(input int lim);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(hmax && vmax) && n < lim);
        if (!(hmax && vmax)) chk("eof_wait", 32'd0, 32'd1);
    endtask

    task automatic wait_ack(input int lim);
        int n;
        n = 0;
        while (!ack && n < lim) begin
            tick();
            n++;
        end
        chk("ack_wait", 32'(ack), 32'd1);
    endtask

    initial begin
        int n;

        // ---------------- reset values ----------------
        #1 reset = 1'b1;
        #1;
        chk("rst_mode",  32'(mode),  32'd0);
        chk("rst_sr",    32'(sr),    32'd1);
        chk("rst_blank", 32'(blank), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_tmo",   32'(tmo),   32'd0);
        chk("rst_fc",    32'(fc),    32'd0);
        chk("rst_mode0", 32'(mode0), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("sr_held_until_edge", 32'(sr), 32'd1);
        tick();
        chk("sr_drop_first_edge", 32'(sr), 32'd0);

        // ---------------- same-mode request ----------------
        req = 1'b1; rmode = 1'b0;
        tick();
        chk("same_ack_edge1", 32'(ack), 32'd0);
        chk("same_busy", 32'(busy), 32'd0);
        tick();
        chk("same_ack_edge2", 32'(ack), 32'd1);
        chk("same_mode", 32'(mode), 32'd0);
        chk("same_sr", 32'(sr), 32'd0);
        chk("same_blank", 32'(blank), 32'd0);
        req = 1'b0;
        tick();
        chk("same_ack_drop", 32'(ack), 32'd0);

        // ---------------- mid-frame switch 0 -> 1 ----------------
        wait_eof(60);
        repeat (17) tick();
        req = 1'b1; rmode = 1'b1;
        tick();
        chk("sw_busy", 32'(busy), 32'd1);
        chk("sw_mode_hold", 32'(mode), 32'd0);
        n = 0;
        while (mode == 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("sw_mode_new", 32'(mode), 32'd1);
        chk("sw_on_eof", 32'(hmax && vmax), 32'd1);
        chk("sw_sr_pulse", 32'(sr), 32'd1);
        chk("sw_blank_on", 32'(blank), 32'd1);
        chk("sw_fc_clear", 32'(fc), 32'd0);
        chk("sw_tmo", 32'(tmo), 32'd0);
        n = 0;
        tick();
        n++;
        chk("sw_sr_one_cycle", 32'(sr), 32'd0);
        while (blank && n < 300) begin
            tick();
            n++;
        end
        chk("sw_blank_cycles", 32'(n), 32'(2 * H * V));
        chk("sw_busy_done", 32'(busy), 32'd0);
        chk("sw_fc_two", 32'(fc), 32'd2);
        tick();
        chk("sw_ack", 32'(ack), 32'd1);
        req = 1'b0;
        tick();
        chk("sw_ack_drop", 32'(ack), 32'd0);

        // ---------------- zero-settle switch 1 -> 0 ----------------
        req0 = 1'b1; rmode0 = 1'b0;
        tick();
        chk("z_busy", 32'(busy0), 32'd1);
        chk("z_mode_hold", 32'(mode0), 32'd1);
        wait_eof(60);
        chk("z_mode_new", 32'(mode0), 32'd0);
        chk("z_sr", 32'(sr0), 32'd1);
        chk("z_busy_done", 32'(busy0), 32'd0);
        chk("z_ack_pre", 32'(ack0), 32'd0);
        tick();
        chk("z_ack", 32'(ack0), 32'd1);
        req0 = 1'b0;
        tick();
        chk("z_ack_drop", 32'(ack0), 32'd0);
        chk("z_never_blank", 32'(blank0_seen), 32'd0);

        // ---------------- watchdog-forced apply 1 -> 0 ----------------
        hen = 1'b0;
        req = 1'b1; rmode = 1'b0;
        tick();
        chk("wd_busy", 32'(busy), 32'd1);
        n = 0;
        while (mode == 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        chk("wd_cycles", 32'(n), 32'd1000);
        chk("wd_timeout", 32'(tmo), 32'd1);
        chk("wd_sr", 32'(sr), 32'd1);
        hen = 1'b1;
        wait_ack(300);
        req = 1'b0;
        tick();
        chk("wd_tmo_sticky", 32'(tmo), 32'd1);

        // ---------------- next change clears timeout, then reset mid-SETTLE ----------------
        req = 1'b1; rmode = 1'b1;
        tick();
        chk("wd_tmo_cleared", 32'(tmo), 32'd0);
        n = 0;
        while (mode == 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk("ar_applied", 32'(mode), 32'd1);
        wait_eof(60);
        repeat (3) tick();
        chk("ar_blank_pre", 32'(blank), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("ar_mode", 32'(mode), 32'd0);
        chk("ar_sr", 32'(sr), 32'd1);
        chk("ar_blank", 32'(blank), 32'd0);
        chk("ar_busy", 32'(busy), 32'd0);
        chk("ar_fc", 32'(fc), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        req = 1'b0;
        tick();
        chk("ar_sr_drop", 32'(sr), 32'd0);
        chk("ar_mode_after", 32'(mode), 32'd0);
        chk("ar_ack_after", 32'(ack), 32'd0);

        // ---------------- frame counter wrap and clear on apply ----------------
        n = 0;
        while (fc != 8'd255 && n < 13500) begin
            tick();
            n++;
        end
        chk("fc_255", 32'(fc), 32'd255);
        wait_eof(60);
        chk("fc_wrap", 32'(fc), 32'd0);
        repeat (100) wait_eof(60);
        chk("fc_100", 32'(fc), 32'd100);
        req = 1'b1; rmode = 1'b1;
        tick();
        wait_eof(60);
        chk("fc_apply_mode", 32'(mode), 32'd1);
        chk("fc_apply_clear", 32'(fc), 32'd0);
        wait_ack(300);
        req = 1'b0;
        tick();
        chk("fc_ack_drop", 32'(ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
Sequences run-time timing-mode changes for the vga_sync generator. Accepts a mode-change request over a four-phase req/ack handshake and applies the new mode only at a frame boundary (hmax & vmax). It pulses the sync generator's reset and forces video blanking for a programmable number of settle frames so the monitor re-locks cleanly. Sits between the top-level control/register logic and vga_sync, and drives vga_sync's mode and reset inputs.

Parameters:
RESET_MODE, 0, mode driven on o_mode after reset (0 = 640x480@60, 1 = 1440x900-div4@60)
SETTLE_FRAMES, 2, frames of forced blanking after a mode switch; legal 0..15
TIMEOUT_CYCLES, 500000, max cycles spent in WAIT_EOF before a forced apply; legal 1..1048575 (20-bit counter)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high reset
i_req  in  1  mode-change request; held high until o_ack is seen
i_req_mode  in  1  requested mode; stable while i_req is high
i_hmax  in  1  from vga_sync o_hmax
i_vmax  in  1  from vga_sync o_vmax
o_mode  out  1  mode to vga_sync
o_sync_reset  out  1  reset to vga_sync
o_blank_force  out  1  forces RGB to black downstream
o_busy  out  1  high in WAIT_EOF and SETTLE
o_ack  out  1  four-phase acknowledge
o_timeout  out  1  sticky: last apply was forced by the watchdog
o_frame_count  out  8  frames since last apply

Behaviour:
- All state flops use asynchronous reset. Reset values:
  - state = IDLE, o_mode = RESET_MODE, o_sync_reset = 1, o_blank_force = 0, o_ack = 0, o_busy = 0, o_timeout = 0, o_frame_count = 0.
  - o_sync_reset drops on the first clk edge after reset deasserts.
- eof = i_hmax & i_vmax. All outputs are registered.
- IDLE:
  - If i_req=1 and i_req_mode == o_mode: go to ACK. No blanking or sync reset.
  - If i_req=1 and i_req_mode != o_mode: latch pending = i_req_mode, clear o_timeout, clear the watchdog counter, set o_busy=1, go to WAIT_EOF.
- WAIT_EOF:
  - Watchdog increments once per cycle.
  - Apply condition: eof, or watchdog == TIMEOUT_CYCLES-1. A watchdog-triggered apply also sets o_timeout=1. If both hit in the same cycle, eof wins and o_timeout stays 0.
  - Apply, taking effect at the next edge:
    - o_mode <= pending.
    - o_sync_reset <= 1 for exactly one cycle.
    - o_frame_count <= 0.
    - Settle counter <= SETTLE_FRAMES.
  - If SETTLE_FRAMES == 0: go to ACK, o_busy <= 0, o_blank_force stays 0.
  - Otherwise: o_blank_force <= 1, go to SETTLE.
- SETTLE:
  - Each eof decrements the settle counter.
  - On the eof where the counter == 1: o_blank_force <= 0, o_busy <= 0, go to ACK.
  - Blanking therefore covers exactly SETTLE_FRAMES full frames after the apply.
- ACK:
  - o_ack = 1 while in ACK.
  - When i_req == 0: o_ack <= 0, go to IDLE.
- Requests are only sampled in IDLE. i_req/i_req_mode changes in any other state are ignored.
- o_frame_count:
  - Increments on every eof in every state, wrapping 255 -> 0.
  - The apply clear has priority over the increment.
- o_sync_reset is also 1 during and immediately after async reset (see above). vga_sync therefore holds hpos/vpos at 0 for that one extra cycle; this is intended.
- Asynchronous reset in any state returns all state and outputs to the reset values immediately. A pending mode is discarded.

Test Plan:
1. Reset, i_req=1, i_req_mode=0 (RESET_MODE=0) -> o_ack=1 two edges after req; o_mode, o_blank_force, o_sync_reset never toggle; drop req -> o_ack=0 next cycle.
2. Mode 0 running, req mode 1 mid-frame (hpos=100, vpos=200) -> o_busy=1; o_mode changes only on the edge after hmax&vmax (799,524); o_sync_reset high exactly 1 cycle; o_blank_force high for 2 frames of 476x932 cycles; then o_ack=1.
3. SETTLE_FRAMES=0, switch 1 -> 0 -> apply at eof, o_blank_force never asserted, o_ack one cycle after apply.
4. Hold i_hmax=0, TIMEOUT_CYCLES=1000, req mode change -> apply at cycle 1000 after acceptance; o_timeout=1; next accepted change clears o_timeout.
5. Assert async reset mid-SETTLE with the counter at 1 -> all outputs return to reset values without a clock edge; o_mode = RESET_MODE; o_sync_reset deasserts on the first edge after release.
6. Free-run 256 frames with no requests -> o_frame_count goes 255 -> 0; a switch clears it to 0 at apply regardless of its value.
